// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile
// I2C target with a 16-byte register file shared between an external I2C
// controller and the CPU (FPro MMIO slot).
//
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   scl_i, sda_i        : raw (asynchronous) I2C pad inputs
//   sda_oe              : 1 pulls SDA low, 0 releases it (open drain)
//   cs, read, write     : MMIO slot select and strobes (reads have no side effect)
//   addr, wr_data       : MMIO word address and write data
//   rd_data             : combinational MMIO read mux
//   dbg_state_o         : current FSM state, for observation only
//
// Register map: 0-15 reg[n] (low byte), 16 status
//   {ptr[7:4], 0, rd_evt, wr_evt, busy}; a write to 16 clears both events.
//
// SDA handshake: sda_oe only changes on the clk after a detected SCL falling
// edge (except release on STOP/reset). ACK slots are driven from the fall
// ending bit 8 to the fall ending bit 9; read data bits are driven after each
// fall and released after bit 0 so the controller can ACK/NACK.
module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic [3:0]  dbg_state_o
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // [0],[1] synchronizer, [2] previous synchronized value for edge detect
    logic [2:0] scl_q, sda_q;
    logic       scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] tx_q, tx_d;
    logic       ack_q, ack_d;
    logic [3:0] ptr_q, ptr_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_evt_q, rd_evt_q;
    logic [7:0] regs_q [16];

    logic       i2c_we, rd_set;
    logic [7:0] rx_byte;
    logic [3:0] ptr_inc;
    logic       busy, mmio_we, status_clr;

    wire unused_ok = &{1'b0, read, wr_data[31:8]};

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_i};
            sda_q <= {sda_q[1:0], sda_i};
        end
    end

    assign scl_s     = scl_q[1];
    assign sda_s     = sda_q[1];
    assign scl_rise  = scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] & scl_q[2];
    assign start_det = ~sda_q[1] & sda_q[2] & scl_s;
    assign stop_det  = sda_q[1] & ~sda_q[2] & scl_s;

    assign rx_byte = {sr_q[6:0], sda_s};
    assign ptr_inc = ptr_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        tx_d     = tx_q;
        ack_d    = ack_q;
        ptr_d    = ptr_q;
        sda_oe_d = sda_oe_q;
        i2c_we   = 1'b0;
        rd_set   = 1'b0;
        if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 4'd0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        sr_d  = rx_byte;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (state_q == ADDR) begin
                                state_d = (sr_q[6:0] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
                            end else if (state_q == PTR) begin
                                ptr_d   = rx_byte[3:0];
                                state_d = PTR_ACK;
                            end else begin
                                i2c_we  = 1'b1;
                                ptr_d   = ptr_inc;
                                state_d = WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall drives the ACK, second fall releases it and
                // moves on; sda_oe_q itself tells the two apart.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (state_q == ADDR_ACK && sr_q[0]) begin
                                tx_d     = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                                state_d  = RDATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            rd_set   = 1'b1;
                            state_d  = RDATA_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[3'd7 - cnt_q[2:0]];
                        end
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise) begin
                        ack_d = ~sda_s;
                    end else if (scl_fall) begin
                        if (ack_q) begin
                            ptr_d    = ptr_inc;
                            tx_d     = regs_q[ptr_inc];
                            sda_oe_d = ~regs_q[ptr_inc][7];
                            cnt_d    = 4'd0;
                            state_d  = RDATA;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            sr_q     <= 8'd0;
            tx_q     <= 8'd0;
            ack_q    <= 1'b0;
            ptr_q    <= 4'd0;
            sda_oe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            tx_q     <= tx_d;
            ack_q    <= ack_d;
            ptr_q    <= ptr_d;
            sda_oe_q <= sda_oe_d;
        end
    end

    assign mmio_we    = cs & write & ~addr[4];
    assign status_clr = cs & write & (addr == 5'd16);

    // The I2C write is placed last so it wins a same-register collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'd0;
            wr_evt_q <= 1'b0;
            rd_evt_q <= 1'b0;
        end else begin
            if (mmio_we) regs_q[addr[3:0]] <= wr_data[7:0];
            if (i2c_we)  regs_q[ptr_q]     <= rx_byte;
            if (status_clr) begin
                wr_evt_q <= 1'b0;
                rd_evt_q <= 1'b0;
            end
            if (i2c_we) wr_evt_q <= 1'b1;
            if (rd_set) rd_evt_q <= 1'b1;
        end
    end

    assign busy = (state_q != IDLE) && (state_q != ADDR) && (state_q != WAIT_STOP);

    always_comb begin
        rd_data = 32'd0;
        if (!addr[4]) begin
            rd_data = {24'd0, regs_q[addr[3:0]]};
        end else if (addr == 5'd16) begin
            rd_data = {24'd0, ptr_q, 1'b0, rd_evt_q, wr_evt_q, busy};
        end
    end

    assign sda_oe      = sda_oe_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: an MMIO vector table plus a bit-banged I2C
// controller (open-drain SDA model) for multi-cycle transactions.
module tb_i2c_target_regfile;

    localparam int Q = 32; // quarter SCL period in clk (SCL period = 128 clk)

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        scl_ctl = 1'b1;
    logic        sda_ctl = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr_v = 5'd0;
    logic [31:0] wdata_v = 32'd0;
    logic [31:0] rd_data;
    logic [3:0]  dbg_state;

    int total = 0;
    int bad = 0;
    int oe_cnt = 0;

    assign sda_line = sda_ctl & ~sda_oe;

    i2c_target_regfile #(.DEV_ADDR(7'h42)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_ctl),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .cs         (cs),
        .read       (rd),
        .write      (wr),
        .addr       (addr_v),
        .wr_data    (wdata_v),
        .rd_data    (rd_data),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sda_oe) oe_cnt++;

    typedef struct packed {
        logic        wr;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mmio_write(input logic [4:0] a, input logic [31:0] d);
        addr_v = a; wdata_v = d; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic mmio_read(input logic [4:0] a, output logic [31:0] d);
        addr_v = a; cs = 1'b1; rd = 1'b1;
        #1;
        d = rd_data;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic i2c_start();
        sda_ctl = 1'b1; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        sda_ctl = 1'b0; wait_clk(Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_ctl = 1'b0; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        sda_ctl = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_ctl = b;    wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(2 * Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_ctl = 1'b1; wait_clk(Q);
        scl_ctl = 1'b1; wait_clk(Q);
        b = sda_line;   wait_clk(Q);
        scl_ctl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(~ack);
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  byte_v;
        logic        ack;
        int          oe_before;

        vecs[0] = '{wr: 1'b1, a: 5'd2,  d: 32'h0000_01A5, exp: 32'h0000_00A5};
        vecs[1] = '{wr: 1'b1, a: 5'd20, d: 32'h0000_00FF, exp: 32'h0000_0000};
        vecs[2] = '{wr: 1'b0, a: 5'd2,  d: 32'h0000_0000, exp: 32'h0000_00A5};
        vecs[3] = '{wr: 1'b1, a: 5'd16, d: 32'h0000_00FF, exp: 32'h0000_0000};
        vecs[4] = '{wr: 1'b1, a: 5'd31, d: 32'h0000_0012, exp: 32'h0000_0000};
        vecs[5] = '{wr: 1'b1, a: 5'd9,  d: 32'hFFFF_FF3C, exp: 32'h0000_003C};

        // reset
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        for (int a = 0; a <= 16; a++) begin
            mmio_read(5'(a), r);
            check($sformatf("reset_rd[%0d]", a), r, 32'd0);
        end
        check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_state", {28'd0, dbg_state}, 32'd0);

        // MMIO table
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vecs[i].wr) mmio_write(vecs[i].a, vecs[i].d);
            mmio_read(vecs[i].a, r);
            check($sformatf("mmio_vec[%0d]", i), r, vecs[i].exp);
        end

        // write with pointer wrap
        @(negedge clk);
        i2c_start();
        write_byte(8'h84, ack); check("wr_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h0F, ack); check("wr_ptr_ack",  {31'd0, ack}, 32'd1);
        write_byte(8'hAA, ack); check("wr_d0_ack",   {31'd0, ack}, 32'd1);
        write_byte(8'h55, ack); check("wr_d1_ack",   {31'd0, ack}, 32'd1);
        i2c_stop();
        mmio_read(5'd15, r); check("reg15", r, 32'hAA);
        mmio_read(5'd0,  r); check("reg0_wrap", r, 32'h55);
        mmio_read(5'd16, r); check("status_after_wr", r, 32'h12);

        // read with repeated START
        @(negedge clk);
        mmio_write(5'd3, 32'h5C);
        mmio_write(5'd4, 32'hA7);
        i2c_start();
        write_byte(8'h84, ack); check("rd_waddr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h03, ack); check("rd_ptr_ack",   {31'd0, ack}, 32'd1);
        i2c_start();
        write_byte(8'h85, ack); check("rd_raddr_ack", {31'd0, ack}, 32'd1);
        read_byte(byte_v, 1'b1); check("rd_byte0", {24'd0, byte_v}, 32'h5C);
        mmio_read(5'd16, r); check("status_mid_read", r, 32'h47);
        @(negedge clk);
        read_byte(byte_v, 1'b0); check("rd_byte1", {24'd0, byte_v}, 32'hA7);
        check("oe_after_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop();
        check("idle_after_stop", {28'd0, dbg_state}, 32'd0);
        mmio_read(5'd16, r); check("status_after_rd", r, 32'h46);

        // wrong device address
        @(negedge clk);
        oe_before = oe_cnt;
        i2c_start();
        write_byte(8'h52, ack); check("wrong_addr_nack", {31'd0, ack}, 32'd0);
        write_byte(8'h01, ack);
        write_byte(8'h99, ack);
        write_byte(8'hEE, ack); check("wrong_data_nack", {31'd0, ack}, 32'd0);
        mmio_read(5'd16, r); check("wrong_status", r, 32'h46);
        @(negedge clk);
        i2c_stop();
        check("wrong_no_oe", oe_cnt - oe_before, 32'd0);
        mmio_read(5'd3, r); check("wrong_reg3", r, 32'h5C);
        mmio_read(5'd9, r); check("wrong_reg9", r, 32'h3C);
        mmio_read(5'd2, r); check("wrong_reg2", r, 32'hA5);

        // same-cycle I2C and MMIO write to reg7
        @(negedge clk);
        i2c_start();
        write_byte(8'h84, ack);
        write_byte(8'h07, ack);
        for (int i = 7; i >= 1; i--) write_bit(1'(8'h11 >> i));
        sda_ctl = 1'b1; wait_clk(Q);
        // 8th SCL rise reaches the register three clk edges later
        scl_ctl = 1'b1; addr_v = 5'd7; wdata_v = 32'h22; cs = 1'b1; wr = 1'b1;
        wait_clk(3);
        cs = 1'b0; wr = 1'b0;
        wait_clk(2 * Q - 3);
        scl_ctl = 1'b0; wait_clk(Q);
        read_bit(ack); check("coll_ack", {31'd0, ack}, 32'd0);
        i2c_stop();
        mmio_read(5'd7, r); check("collision_reg7", r, 32'h11);
        mmio_read(5'd16, r); check("status_before_clr", r, 32'h86);
        @(negedge clk);
        mmio_write(5'd16, 32'h1);
        mmio_read(5'd16, r); check("status_cleared", r, 32'h80);

        // reset during ADDR_ACK
        @(negedge clk);
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(1'(8'h84 >> i));
        check("ack_driven", {31'd0, sda_oe}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("oe_after_reset", {31'd0, sda_oe}, 32'd0);
        reset = 1'b0;
        wait_clk(4);
        i2c_start();
        write_byte(8'h84, ack); check("post_rst_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h05, ack); check("post_rst_ptr_ack",  {31'd0, ack}, 32'd1);
        write_byte(8'h77, ack); check("post_rst_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        mmio_read(5'd5, r);  check("post_rst_reg5", r, 32'h77);
        mmio_read(5'd16, r); check("post_rst_status", r, 32'h62);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
